ipsxe_floating_point_input_cond_v1_0: RTL and testbench
=======================================================

// Module: ipsxe_floating_point_input_cond_v1_0
// PURPOSE
//  Parametrised input-conditioning stage for the FP arithmetic cores (fma, add, mul).
//  Accepts NUM_OPS packed IEEE-754 operands per beat on a valid/ready handshake.
//  Per operand it classifies the value, applies a selectable denormal policy and emits the
//  conditioned operands and class codes one cycle later.
//  A 2-entry skid buffer gives full throughput under backpressure; per-operand sticky
//  denormal flags are kept for status reporting.
// PARAMETERS
//  EXP_WIDTH  8   exponent field width (>=2)
//  SIG_WIDTH  23  stored mantissa width (>=1)
//  NUM_OPS    3   operands per beat, 1..4
//  FTZ_MODE   2   denormal policy: 0 = pass unchanged; 1 = flush to signed zero;
//                 2 = flush to +0 (all bits zero)
// PORTS
//  i_clk        in   1            clock; all logic rising-edge
//  i_rst_n      in   1            asynchronous active-low reset
//  i_valid      in   1            input beat valid
//  o_ready      out  1            stage can accept a beat
//  i_data       in   NUM_OPS*W    packed operands, op k at [k*W +: W], W=1+EXP_WIDTH+SIG_WIDTH
//  o_valid      out  1            output beat valid
//  i_ready      in   1            downstream accepts beat
//  o_data       out  NUM_OPS*W    conditioned operands, same packing
//  o_class      out  NUM_OPS*3    class per op: 0 norm, 1 zero, 2 denorm, 3 inf, 4 qnan, 5 snan
//  i_flag_clr   in   1            synchronous clear of sticky flags
//  o_denorm_stk out  NUM_OPS      sticky: op k was denormal in an accepted beat
// BEHAVIOUR
//  - Reset values: o_valid=0, o_ready=1, o_data=0, o_class=0, o_denorm_stk=0, skid empty.
//  - Input transfer: i_valid&o_ready. Output transfer: o_valid&i_ready.
//  - Latency: exactly 1 cycle from input transfer to o_valid when the output register is
//    empty or draining. Throughput: 1 beat/cycle while i_ready=1.
//  - Classification, with E = exponent and M = mantissa:
//      E=0,M=0       -> zero
//      E=0,M!=0      -> denorm
//      E=all1,M=0    -> inf
//      E=all1,M[msb]=1 -> qnan
//      E=all1,M[msb]=0,M!=0 -> snan
//      otherwise     -> norm
//  - Class codes are reported on the original (pre-flush) value.
//  - Flush rules:
//      FTZ_MODE=1: denorm -> {sign, 0...}
//      FTZ_MODE=2: denorm -> 0
//      FTZ_MODE=0: value passed bit-exact
//      NaN/inf/zero/norm are never modified.
//  - Pipeline: main output register plus one skid register.
//      o_ready is registered and equals skid-empty.
//      Input transfer while o_valid&!i_ready: the beat goes to skid and o_ready drops next cycle.
//      Output transfer with skid full: skid moves into the output register and o_ready rises
//      next cycle.
//      Skid full and output stalled: no input is accepted; data is held stable.
//      Once o_valid=1, o_data/o_class must not change until transferred.
//  - Sticky flags: set on input transfer for each op classified denorm, in every FTZ_MODE.
//    i_flag_clr clears all flags. Same-cycle set and clear: set wins (flag reads 1 next cycle).
//  - Reset asserted mid-operation: in-flight and skid beats are discarded and all outputs
//    return to reset values immediately (asynchronously).
//  - NUM_OPS outside 1..4 or FTZ_MODE>2: elaboration error.
// STRUCTURE
//  - Shared package/include (ipsxe_floating_point_pkg): class encodings (FP_CLS_*), FTZ mode
//    constants, width helper W.
//  - Sub-module ipsxe_floating_point_fp_classify_v1_0 (combinational, EXP_WIDTH/SIG_WIDTH/
//    FTZ_MODE): returns class and flushed value. One instance per operand via generate.
//  - Top: generate loop, output register and skid register, sticky-flag register.
// TESTING  (EXP=8, SIG=23, NUM_OPS=3)
//  1. FTZ_MODE=2, op0=0x00000001, op1=0x80000001, op2=0x3F800000
//     -> 1 cycle later o_data ops {0x00000000, 0x00000000, 0x3F800000};
//        class {2, 2, 0}; o_denorm_stk=3'b011.
//  2. FTZ_MODE=1, same beat -> ops {0x00000000, 0x80000000, 0x3F800000}.
//     FTZ_MODE=0 -> data bit-exact; class still {2, 2, 0}.
//  3. ops {0x7F800000, 0x7FC00000, 0x7F800001} -> class {3, 4, 5}; data unchanged in all modes.
//  4. Backpressure: 8 back-to-back beats, i_ready low for cycles 2-4
//     -> o_ready low from cycle after skid fill; no beat lost or duplicated;
//        output order preserved; o_data stable while stalled.
//  5. i_flag_clr asserted in the same cycle as a denorm beat on op2 -> o_denorm_stk[2]=1 after.
//     Clear with no denorm -> 0.
//  6. Deassert i_rst_n with skid full
//     -> o_valid=0, o_ready=1, flags=0; first post-reset beat appears with 1-cycle latency.

Source files
------------

// File: rtl/ipsxe_floating_point_pkg.sv
// Shared definitions for the FP input-conditioning blocks: class codes,
// denormal-policy selectors and the packed operand width helper.
package ipsxe_floating_point_pkg;

  typedef enum logic [2:0] {
    FP_CLS_NORM   = 3'd0,
    FP_CLS_ZERO   = 3'd1,
    FP_CLS_DENORM = 3'd2,
    FP_CLS_INF    = 3'd3,
    FP_CLS_QNAN   = 3'd4,
    FP_CLS_SNAN   = 3'd5
  } fp_class_e;

  localparam int FTZ_PASS   = 0;
  localparam int FTZ_SIGNED = 1;
  localparam int FTZ_ZERO   = 2;

  localparam int FP_CLS_WIDTH = 3;

  function automatic int fp_width(input int exp_w, input int sig_w);
    return 1 + exp_w + sig_w;
  endfunction

endpackage

// File: rtl/ipsxe_floating_point_fp_classify_v1_0.sv
// Combinational classifier for one IEEE-754 operand; also applies the
// selected denormal flush policy. The class always reflects the raw input.
module ipsxe_floating_point_fp_classify_v1_0
  import ipsxe_floating_point_pkg::*;
#(
  parameter int EXP_WIDTH = 8,
  parameter int SIG_WIDTH = 23,
  parameter int FTZ_MODE  = 2,
  localparam int W = 1 + EXP_WIDTH + SIG_WIDTH
) (
  input  logic [W-1:0] op_i,
  output logic [2:0]   class_o,
  output logic [W-1:0] op_o
);

  logic                 sign;
  logic [EXP_WIDTH-1:0] expo;
  logic [SIG_WIDTH-1:0] mant;
  fp_class_e            cls;

  assign sign = op_i[W-1];
  assign expo = op_i[W-2 -: EXP_WIDTH];
  assign mant = op_i[SIG_WIDTH-1:0];

  always_comb begin
    cls = FP_CLS_NORM;
    if (expo == '0) begin
      cls = (mant == '0) ? FP_CLS_ZERO : FP_CLS_DENORM;
    end else if (&expo) begin
      if (mant == '0)              cls = FP_CLS_INF;
      else if (mant[SIG_WIDTH-1])  cls = FP_CLS_QNAN;
      else                         cls = FP_CLS_SNAN;
    end
  end

  always_comb begin
    op_o = op_i;
    if (cls == FP_CLS_DENORM) begin
      if (FTZ_MODE == FTZ_SIGNED)    op_o = {sign, {(W-1){1'b0}}};
      else if (FTZ_MODE == FTZ_ZERO) op_o = '0;
    end
  end

  assign class_o = cls;

endmodule

// File: rtl/ipsxe_floating_point_input_cond_v1_0.sv
// Input-conditioning stage: per-operand classify/flush, one-cycle output
// register backed by a single skid entry, and sticky per-operand denormal flags.
module ipsxe_floating_point_input_cond_v1_0
  import ipsxe_floating_point_pkg::*;
#(
  parameter int EXP_WIDTH = 8,
  parameter int SIG_WIDTH = 23,
  parameter int NUM_OPS   = 3,
  parameter int FTZ_MODE  = 2,
  localparam int W = 1 + EXP_WIDTH + SIG_WIDTH
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [NUM_OPS*W-1:0]           i_data,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [NUM_OPS*W-1:0]           o_data,
  output logic [NUM_OPS*FP_CLS_WIDTH-1:0] o_class,
  input  logic                           i_flag_clr,
  output logic [NUM_OPS-1:0]             o_denorm_stk
);

  if (NUM_OPS < 1 || NUM_OPS > 4 || FTZ_MODE < 0 || FTZ_MODE > 2 ||
      EXP_WIDTH < 2 || SIG_WIDTH < 1) begin : g_bad_param
    $error("ipsxe_floating_point_input_cond_v1_0: illegal parameter set");
  end

  logic [NUM_OPS*W-1:0]            cond_data;
  logic [NUM_OPS*FP_CLS_WIDTH-1:0] cond_cls;
  logic [NUM_OPS-1:0]              cond_dn;

  for (genvar k = 0; k < NUM_OPS; k++) begin : g_op
    ipsxe_floating_point_fp_classify_v1_0 #(
      .EXP_WIDTH(EXP_WIDTH),
      .SIG_WIDTH(SIG_WIDTH),
      .FTZ_MODE (FTZ_MODE)
    ) u_classify (
      .op_i   (i_data[k*W +: W]),
      .class_o(cond_cls[k*FP_CLS_WIDTH +: FP_CLS_WIDTH]),
      .op_o   (cond_data[k*W +: W])
    );
    assign cond_dn[k] = (cond_cls[k*FP_CLS_WIDTH +: FP_CLS_WIDTH] == FP_CLS_DENORM);
  end

  logic                            out_valid_q, out_valid_d;
  logic [NUM_OPS*W-1:0]            out_data_q, out_data_d;
  logic [NUM_OPS*FP_CLS_WIDTH-1:0] out_cls_q, out_cls_d;
  logic                            skid_valid_q, skid_valid_d;
  logic [NUM_OPS*W-1:0]            skid_data_q, skid_data_d;
  logic [NUM_OPS*FP_CLS_WIDTH-1:0] skid_cls_q, skid_cls_d;
  logic                            ready_q, ready_d;
  logic [NUM_OPS-1:0]              stk_q, stk_d;
  logic                            in_xfer, out_xfer;

  // Handshake: a beat moves when valid and ready are both high at the rising
  // edge; a presented output beat holds its data until it is taken.
  assign in_xfer  = i_valid & ready_q;
  assign out_xfer = out_valid_q & i_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_cls_d    = out_cls_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_cls_d   = skid_cls_q;
    if (!out_valid_q || out_xfer) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_cls_d    = skid_cls_q;
        skid_valid_d = 1'b0;
      end else if (in_xfer) begin
        out_valid_d = 1'b1;
        out_data_d  = cond_data;
        out_cls_d   = cond_cls;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      // Output stalled: park the accepted beat; ready is low only when skid is full.
      skid_valid_d = 1'b1;
      skid_data_d  = cond_data;
      skid_cls_d   = cond_cls;
    end
    ready_d = ~skid_valid_d;
    stk_d   = (i_flag_clr ? '0 : stk_q) | (in_xfer ? cond_dn : '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_cls_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_cls_q   <= '0;
      ready_q      <= 1'b1;
      stk_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_cls_q    <= out_cls_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_cls_q   <= skid_cls_d;
      ready_q      <= ready_d;
      stk_q        <= stk_d;
    end
  end

  assign o_ready      = ready_q;
  assign o_valid      = out_valid_q;
  assign o_data       = out_data_q;
  assign o_class      = out_cls_q;
  assign o_denorm_stk = stk_q;

endmodule

// File: tb/tb_ipsxe_floating_point_input_cond_v1_0.sv
// Bench: three instances (denormal policies 0/1/2) share one stimulus stream;
// each has its own expected queue and monitor fed by a behavioural model.
module tb_ipsxe_floating_point_input_cond_v1_0;

  localparam int EW  = 8;
  localparam int SW  = 23;
  localparam int NOP = 3;
  localparam int W   = 1 + EW + SW;
  localparam int DW  = NOP * W;
  localparam int CW  = NOP * 3;
  localparam int QW  = CW + DW;

  logic          clk;
  logic          rst_n;
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          i_ready;
  logic          i_flag_clr;

  logic          o_ready_w [3];
  logic          o_valid_w [3];
  logic [DW-1:0] o_data_w  [3];
  logic [CW-1:0] o_class_w [3];
  logic [NOP-1:0] stk_w    [3];

  int checks;
  int errors;
  logic saw_stall;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int m, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s mode%0d: got %h expected %h", name, m, act, exp);
    end
  endtask

  // Reference: classify each operand from its fields, then apply the policy.
  function automatic logic [QW-1:0] model(input logic [DW-1:0] d, input int mode);
    logic [DW-1:0] od;
    logic [CW-1:0] oc;
    logic [31:0]   x;
    logic [31:0]   y;
    logic [2:0]    c;
    od = '0;
    oc = '0;
    for (int k = 0; k < NOP; k++) begin
      x = d[k*W +: W];
      if (x[30:23] == 8'h00 && x[22:0] == 0)      c = 3'd1;
      else if (x[30:23] == 8'h00)                 c = 3'd2;
      else if (x[30:23] == 8'hFF && x[22:0] == 0) c = 3'd3;
      else if (x[30:23] == 8'hFF && x[22])        c = 3'd4;
      else if (x[30:23] == 8'hFF)                 c = 3'd5;
      else                                        c = 3'd0;
      y = x;
      if (c == 3'd2 && mode == 1) y = x & 32'h8000_0000;
      if (c == 3'd2 && mode == 2) y = 32'h0;
      od[k*W +: W] = y;
      oc[k*3 +: 3] = c;
    end
    return {oc, od};
  endfunction

  function automatic logic [NOP-1:0] model_dn(input logic [DW-1:0] d);
    logic [NOP-1:0] r;
    logic [CW-1:0]  c;
    logic [QW-1:0]  full;
    full = model(d, 0);
    c = full[QW-1 -: CW];
    for (int k = 0; k < NOP; k++) r[k] = (c[k*3 +: 3] == 3'd2);
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] x;
    logic [22:0] m;
    m = 23'($urandom);
    x[31] = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 5))
      0: x[30:0] = '0;
      1: x[30:0] = {8'h00, (m == 0) ? 23'd1 : m};
      2: x[30:0] = {8'hFF, 23'd0};
      3: x[30:0] = {8'hFF, 1'b1, m[21:0]};
      4: x[30:0] = {8'hFF, 1'b0, (m[21:0] == 0) ? 22'd1 : m[21:0]};
      default: x[30:0] = {8'($urandom_range(1, 254)), m};
    endcase
    return x;
  endfunction

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] d;
    for (int k = 0; k < NOP; k++) d[k*W +: W] = rand_op();
    return d;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ipsxe_floating_point_input_cond_v1_0 #(
      .EXP_WIDTH(EW), .SIG_WIDTH(SW), .NUM_OPS(NOP), .FTZ_MODE(g)
    ) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_valid     (i_valid),
      .o_ready     (o_ready_w[g]),
      .i_data      (i_data),
      .o_valid     (o_valid_w[g]),
      .i_ready     (i_ready),
      .o_data      (o_data_w[g]),
      .o_class     (o_class_w[g]),
      .i_flag_clr  (i_flag_clr),
      .o_denorm_stk(stk_w[g])
    );

    logic [QW-1:0]  exp_q[$];
    logic [NOP-1:0] exp_stk;

    // Queue depth equals beats held inside the DUT after the last edge.
    always @(negedge clk) begin
      if (!rst_n) begin
        exp_q.delete();
        exp_stk = '0;
      end else begin
        chk("ready", g, 128'(o_ready_w[g]), 128'(exp_q.size() < 2));
        chk("valid", g, 128'(o_valid_w[g]), 128'(exp_q.size() > 0));
        chk("sticky", g, 128'(stk_w[g]), 128'(exp_stk));
        if (o_valid_w[g] && exp_q.size() > 0) begin
          chk("beat", g, 128'({o_class_w[g], o_data_w[g]}), 128'(exp_q[0]));
          if (i_ready) void'(exp_q.pop_front());
        end
        if (i_valid && o_ready_w[g]) exp_q.push_back(model(i_data, g));
        exp_stk = (i_flag_clr ? '0 : exp_stk) |
                  ((i_valid && o_ready_w[g]) ? model_dn(i_data) : '0);
      end
    end
  end

  task automatic send(input logic [DW-1:0] d);
    logic ok;
    ok = 1'b0;
    i_data  = d;
    i_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      ok = o_ready_w[2];
      if (!ok) saw_stall = 1'b1;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) chk("send_timeout", 2, 128'(0), 128'(1));
    i_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_vals();
    for (int m = 0; m < 3; m++) begin
      chk("rst_valid", m, 128'(o_valid_w[m]), 128'(0));
      chk("rst_ready", m, 128'(o_ready_w[m]), 128'(1));
      chk("rst_data", m, 128'(o_data_w[m]), 128'(0));
      chk("rst_class", m, 128'(o_class_w[m]), 128'(0));
      chk("rst_sticky", m, 128'(stk_w[m]), 128'(0));
    end
  endtask

  initial begin
    logic [DW-1:0] exp_d [3];
    checks     = 0;
    errors     = 0;
    saw_stall  = 1'b0;
    rst_n      = 1'b0;
    i_valid    = 1'b0;
    i_data     = '0;
    i_ready    = 1'b1;
    i_flag_clr = 1'b0;
    tick(3);
    check_reset_vals();
    rst_n = 1'b1;
    tick(2);

    // Denormal flush in all three policies, one-cycle latency
    send({32'h3F800000, 32'h80000001, 32'h00000001});
    exp_d[0] = {32'h3F800000, 32'h80000001, 32'h00000001};
    exp_d[1] = {32'h3F800000, 32'h80000000, 32'h00000000};
    exp_d[2] = {32'h3F800000, 32'h00000000, 32'h00000000};
    @(negedge clk);
    for (int m = 0; m < 3; m++) begin
      chk("lat_valid", m, 128'(o_valid_w[m]), 128'(1));
      chk("dn_data", m, 128'(o_data_w[m]), 128'(exp_d[m]));
      chk("dn_class", m, 128'(o_class_w[m]), 128'(9'b000_010_010));
      chk("dn_sticky", m, 128'(stk_w[m]), 128'(3'b011));
    end
    tick(2);

    // Inf / qNaN / sNaN untouched
    send({32'h7F800001, 32'h7FC00000, 32'h7F800000});
    @(negedge clk);
    for (int m = 0; m < 3; m++) begin
      chk("nan_data", m, 128'(o_data_w[m]), 128'({32'h7F800001, 32'h7FC00000, 32'h7F800000}));
      chk("nan_class", m, 128'(o_class_w[m]), 128'(9'b101_100_011));
    end
    tick(2);

    // Set beats clear in the same cycle, then a plain clear
    i_flag_clr = 1'b1;
    send({32'h00000005, 32'h3F800000, 32'h40000000});
    i_flag_clr = 1'b0;
    @(negedge clk);
    for (int m = 0; m < 3; m++) chk("clr_set", m, 128'(stk_w[m]), 128'(3'b100));
    tick(1);
    i_flag_clr = 1'b1;
    tick(1);
    i_flag_clr = 1'b0;
    @(negedge clk);
    for (int m = 0; m < 3; m++) chk("clr_only", m, 128'(stk_w[m]), 128'(3'b000));
    tick(2);

    // Back-to-back beats with a three-cycle downstream stall
    saw_stall = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) send(rand_beat());
      end
      begin
        i_ready = 1'b1;
        tick(2);
        i_ready = 1'b0;
        tick(3);
        i_ready = 1'b1;
      end
    join
    chk("skid_filled", 2, 128'(saw_stall), 128'(1));
    tick(6);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      i_valid    = ($urandom_range(0, 3) != 0);
      i_data     = rand_beat();
      i_ready    = ($urandom_range(0, 3) != 0);
      i_flag_clr = ($urandom_range(0, 15) == 0);
      tick(1);
    end
    i_valid    = 1'b0;
    i_ready    = 1'b1;
    i_flag_clr = 1'b0;
    tick(6);

    // Reset with the skid full, then recovery
    i_ready = 1'b0;
    send(rand_beat());
    send(rand_beat());
    @(negedge clk);
    for (int m = 0; m < 3; m++) chk("full_ready", m, 128'(o_ready_w[m]), 128'(0));
    tick(1);
    rst_n = 1'b0;
    #2;
    check_reset_vals();
    tick(1);
    rst_n   = 1'b1;
    i_ready = 1'b1;
    tick(1);
    send({32'h00000003, 32'h7FC00000, 32'hBF800000});
    exp_d[0] = {32'h00000003, 32'h7FC00000, 32'hBF800000};
    exp_d[1] = {32'h00000000, 32'h7FC00000, 32'hBF800000};
    exp_d[2] = {32'h00000000, 32'h7FC00000, 32'hBF800000};
    @(negedge clk);
    for (int m = 0; m < 3; m++) begin
      chk("post_rst_valid", m, 128'(o_valid_w[m]), 128'(1));
      chk("post_rst_data", m, 128'(o_data_w[m]), 128'(exp_d[m]));
      chk("post_rst_class", m, 128'(o_class_w[m]), 128'(9'b010_100_000));
    end
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
